// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory load/store unit: pipeline-wide constants,
// memory op codes, FSM state encodings and the decode/alignment helpers.
// Optional feature macro: MEM_LSU_LLSC_EN (adds the LL/SC op codes).
package mem_lsu_pkg;

  // Pipeline constants used by the surrounding datapath
  localparam int          DATA_W     = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        WRITE_EN   = 1'b1;
  localparam logic        WRITE_DIS  = 1'b0;

  // Reset is active-low
  localparam logic        RST_ACTIVE = 1'b0;

  // Width of the ACCESS cycle counter (TIMEOUT is at most 65535)
  localparam int          CNT_W      = 16;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
`ifdef MEM_LSU_LLSC_EN
    ,
    OP_LL   = 4'd9,
    OP_SC   = 4'd10
`endif
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Unknown or disabled codes collapse to OP_NONE so they pass through.
  function automatic mem_op_e decode_op(input logic [3:0] code);
    mem_op_e op;
    case (code)
      4'd1:    op = OP_LB;
      4'd2:    op = OP_LBU;
      4'd3:    op = OP_LH;
      4'd4:    op = OP_LHU;
      4'd5:    op = OP_LW;
      4'd6:    op = OP_SB;
      4'd7:    op = OP_SH;
      4'd8:    op = OP_SW;
`ifdef MEM_LSU_LLSC_EN
      4'd9:    op = OP_LL;
      4'd10:   op = OP_SC;
`endif
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    logic st;
    st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
`ifdef MEM_LSU_LLSC_EN
    st = st || (op == OP_SC);
`endif
    return st;
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
    logic half_op;
    logic word_op;
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word_op = (op == OP_LW) || (op == OP_SW);
`ifdef MEM_LSU_LLSC_EN
    word_op = word_op || (op == OP_LL) || (op == OP_SC);
`endif
    return (half_op && off[0]) || (word_op && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Load data extraction: picks the addressed byte/halfword out of the returned
// word according to BIG_ENDIAN and sign- or zero-extends it. Purely
// combinational; word loads pass the word unchanged.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  mem_op_e     i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [1:0]  w_lane;
  logic        w_hsel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select and extension for the byte/halfword loads
  always_comb begin
    w_lane = (BIG_ENDIAN != 0) ? ~i_off : i_off;
    w_hsel = (BIG_ENDIAN != 0) ? ~i_off[1] : i_off[1];
    w_byte = i_rdata[{w_lane, 3'b000} +: 8];
    w_half = w_hsel ? i_rdata[31:16] : i_rdata[15:0];
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h000000, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage load/store unit. Non-memory instructions pass straight through;
// memory ops run a single-outstanding bus access (IDLE -> ACCESS -> DONE),
// stalling the pipeline from the issue cycle until the result is ready.
// Optional feature macro: MEM_LSU_LLSC_EN (LL/SC with link bit and llbit_clr_i).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            mem_op_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           reg2_i,
`ifdef MEM_LSU_LLSC_EN
  input  logic                  llbit_clr_i,
`endif
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [3:0]            dmem_sel,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  stall_req,
  output logic                  exc_align_o,
  output logic                  exc_bus_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  mem_op_e          r_op;
  logic [1:0]       r_off;
  logic             r_bus_err;
  logic             r_req;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  mem_op_e          w_op;
  logic             w_misalign;
  logic             w_sc_fail;
  logic             w_issue;
  logic             w_stall;
  logic [1:0]       w_lane;
  logic             w_hlane;
  logic [3:0]       w_sel;
  logic [31:0]      w_wdata;
  logic [31:0]      w_load_data;
  logic             w_wreg;
  logic [31:0]      w_wdata_o;
  logic             w_exc_align;
  logic             w_exc_bus;

  assign w_op       = decode_op(mem_op_i);
  assign w_misalign = is_misaligned(w_op, mem_addr_i[1:0]);

`ifdef MEM_LSU_LLSC_EN
  logic r_llbit;

  // A failing SC completes in the issue cycle without touching the bus.
  assign w_sc_fail = (w_op == OP_SC) && !r_llbit && !w_misalign;

  // Link bit: set by a completed LL, cleared by any SC or an external clear
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      r_llbit <= 1'b0;
    end else if (llbit_clr_i) begin
      r_llbit <= 1'b0;
    end else if ((r_state == ST_IDLE) && (w_op == OP_SC)) begin
      r_llbit <= 1'b0;
    end else if ((r_state == ST_DONE) && (r_op == OP_LL) && !r_bus_err) begin
      r_llbit <= 1'b1;
    end
  end
`else
  assign w_sc_fail = 1'b0;
`endif

  assign w_issue = (r_state == ST_IDLE) && (w_op != OP_NONE) && !w_misalign && !w_sc_fail;
  // The issue cycle stalls too, otherwise the pipeline would move the op away.
  assign w_stall = w_issue || (r_state == ST_ACCESS);

  // Store lane placement: replicate data on every lane, enable only the addressed ones
  always_comb begin
    w_lane  = (BIG_ENDIAN != 0) ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
    w_hlane = (BIG_ENDIAN != 0) ? ~mem_addr_i[1] : mem_addr_i[1];
    w_sel   = 4'hF;
    w_wdata = reg2_i;
    case (w_op)
      OP_SB: begin
        w_sel   = 4'b0001 << w_lane;
        w_wdata = {4{reg2_i[7:0]}};
      end
      OP_SH: begin
        w_sel   = w_hlane ? 4'b1100 : 4'b0011;
        w_wdata = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Access FSM; bus request fields are captured at issue and held through ACCESS
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rdata   <= ZERO_WORD;
      r_op      <= OP_NONE;
      r_off     <= 2'b00;
      r_bus_err <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= 4'h0;
      r_addr    <= ZERO_WORD;
      r_wdata   <= ZERO_WORD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state   <= ST_ACCESS;
            r_cnt     <= '0;
            r_op      <= w_op;
            r_off     <= mem_addr_i[1:0];
            r_bus_err <= 1'b0;
            r_req     <= 1'b1;
            r_we      <= is_store(w_op);
            r_sel     <= w_sel;
            r_addr    <= {mem_addr_i[31:2], 2'b00};
            r_wdata   <= w_wdata;
          end
        end
        ST_ACCESS: begin
          // An ack on the last allowed cycle still counts as a normal completion.
          if (dmem_ack) begin
            r_rdata <= dmem_rdata;
            r_req   <= 1'b0;
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata   <= ZERO_WORD;
            r_bus_err <= 1'b1;
            r_req     <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  mem_lsu_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .i_op    (r_op),
    .i_off   (r_off),
    .i_rdata (r_rdata),
    .o_data  (w_load_data)
  );

  // Writeback selection: passthrough, alignment fault, in-flight, or completed access
  always_comb begin
    w_wreg      = wreg_i;
    w_wdata_o   = wdata_i;
    w_exc_align = 1'b0;
    w_exc_bus   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_misalign) begin
          w_exc_align = 1'b1;
          w_wreg      = WRITE_DIS;
        end else if (w_sc_fail) begin
          w_wdata_o = ZERO_WORD;
        end else if (w_issue) begin
          w_wreg = WRITE_DIS;
        end
      end
      ST_ACCESS: begin
        w_wreg = WRITE_DIS;
      end
      ST_DONE: begin
        if (r_bus_err) begin
          w_exc_bus = 1'b1;
          w_wreg    = WRITE_DIS;
`ifdef MEM_LSU_LLSC_EN
        end else if (r_op == OP_SC) begin
          w_wdata_o = 32'd1;
`endif
        end else if (r_we) begin
          w_wreg = WRITE_DIS;
        end else begin
          w_wdata_o = w_load_data;
        end
      end
      default: begin
        w_wreg = WRITE_DIS;
      end
    endcase
  end

  // Everything is held at zero while reset is low, including mid-access.
  assign dmem_req    = rst & r_req;
  assign dmem_we     = rst & r_we;
  assign dmem_sel    = rst ? r_sel : 4'h0;
  assign dmem_addr   = rst ? r_addr : ZERO_WORD;
  assign dmem_wdata  = rst ? r_wdata : ZERO_WORD;
  assign stall_req   = rst & w_stall;
  assign exc_align_o = rst & w_exc_align;
  assign exc_bus_o   = rst & w_exc_bus;
  assign wd_o        = rst ? wd_i : '0;
  assign wreg_o      = rst & w_wreg;
  assign wdata_o     = rst ? w_wdata_o : ZERO_WORD;
  assign hi_o        = rst ? hi_i : ZERO_WORD;
  assign lo_o        = rst ? lo_i : ZERO_WORD;
  assign whilo_o     = rst & whilo_i & ~w_stall;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a driver issues ops and pushes the model's
// expected writeback and bus request; a monitor and a bus responder pop and
// compare independently.
module tb_mem_lsu;

  localparam int TMO = 4;
  localparam int BIG = 1;
`ifdef MEM_LSU_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        llbit_clr_i;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_sel;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall_req, exc_align_o, exc_bus_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o;

  always #5 clk = ~clk;

  mem_lsu #(.REG_ADDR_W(5), .TIMEOUT(TMO), .BIG_ENDIAN(BIG)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
`ifdef MEM_LSU_LLSC_EN
    .llbit_clr_i(llbit_clr_i),
`endif
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_sel(dmem_sel),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_req(stall_req),
    .exc_align_o(exc_align_o), .exc_bus_o(exc_bus_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o)
  );

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    bit          chk_data;
    logic        align;
    logic        bus;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    int          stall;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          delay;
  } req_t;

  exp_t        sb_q[$];
  req_t        rq_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] bus_mem[16];
  bit          llbit = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] w, input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> ((BIG != 0) ? (3 - off) * 8 : off * 8)) & 32'hFF;
    h = (w >> ((BIG != 0) ? (2 - off) * 8 : off * 8)) & 32'hFFFF;
    case (op)
      1:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      2:       return b;
      3:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4:       return h;
      default: return w;
    endcase
  endfunction

  task automatic drive_random_side();
    wd_i    = 5'($urandom);
    wreg_i  = 1'($urandom);
    wdata_i = $urandom;
    hi_i    = $urandom;
    lo_i    = $urandom;
    whilo_i = 1'($urandom);
  endtask

  // Issue one instruction, record expectations, hold it until it retires.
  task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] reg2,
                       input int delay, input bit clr);
    exp_t e;
    req_t r;
    bit none, ld, st, mis, bus, done;
    int sz, idx;
    logic [1:0]  off;
    logic [31:0] m;
    drive_random_side();
    mem_op_i    = 4'(op);
    mem_addr_i  = addr;
    reg2_i      = reg2;
    llbit_clr_i = clr;
    none = (op == 0) || (op > 10) || (!LLSC && op > 8);
    ld   = !none && (op <= 5 || op == 9);
    st   = !none && !ld;
    sz   = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
    off  = addr[1:0];
    mis  = !none && ((sz == 2 && off[0]) || (sz == 4 && off != 2'b00));
    idx  = int'(addr[5:2]);
    e.wd = wd_i; e.wreg = wreg_i; e.wdata = wdata_i; e.chk_data = 1'b1;
    e.align = 1'b0; e.bus = 1'b0; e.hi = hi_i; e.lo = lo_i; e.whilo = whilo_i; e.stall = 0;
    if (!none) begin
      if (mis) begin
        e.align = 1'b1; e.wreg = 1'b0; e.chk_data = 1'b0;
        if (op == 10) llbit = 1'b0;
      end else if (op == 10 && !llbit) begin
        e.wdata = 32'd0;
      end else begin
        bus     = (delay + 1) > TMO;
        e.bus   = bus;
        e.stall = 1 + (bus ? TMO : delay + 1);
        r.addr  = {addr[31:2], 2'b00};
        r.we    = st;
        r.delay = delay;
        if (sz == 1) begin
          r.sel = 4'(1 << ((BIG != 0) ? 3 - off : off));
          r.wdata = (reg2 & 32'hFF) * 32'h0101_0101;
        end else if (sz == 2) begin
          r.sel = 4'(3 << ((BIG != 0) ? 2 - off : off));
          r.wdata = (reg2 & 32'hFFFF) * 32'h0001_0001;
        end else begin
          r.sel = 4'hF;
          r.wdata = reg2;
        end
        if (bus) begin
          e.wreg = 1'b0; e.chk_data = 1'b0;
        end else if (ld) begin
          e.wdata = ref_load(op, ref_mem[idx], off);
        end else begin
          for (int i = 0; i < 4; i++)
            if (r.sel[i]) begin
              m = 32'hFF << (8 * i);
              ref_mem[idx] = (ref_mem[idx] & ~m) | (r.wdata & m);
            end
          if (op == 10) e.wdata = 32'd1;
          else begin e.wreg = 1'b0; e.chk_data = 1'b0; end
        end
        if (op == 9 && !bus) llbit = 1'b1;
        rq_q.push_back(r);
      end
      if (op == 10) llbit = 1'b0;
    end
    if (clr) llbit = 1'b0;
    sb_q.push_back(e);
    done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!stall_req) begin
        done = 1'b1;
        break;
      end
    end
    check("retire_in_budget", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, exc_align_o, exc_bus_o,
             stall_req, dmem_req, dmem_we, dmem_sel, dmem_addr, dmem_wdata};
  endfunction

  // Monitor: checks stalled cycles and compares each retired instruction.
  initial begin : monitor
    exp_t e;
    int   stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0;
      end else if (stall_req) begin
        stall_cnt++;
        check("wreg_during_stall", 32'(wreg_o), 32'd0);
        check("whilo_during_stall", 32'(whilo_o), 32'd0);
      end else begin
        check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("wd_o", 32'(wd_o), 32'(e.wd));
          check("wreg_o", 32'(wreg_o), 32'(e.wreg));
          if (e.chk_data) check("wdata_o", wdata_o, e.wdata);
          check("exc_align_o", 32'(exc_align_o), 32'(e.align));
          check("exc_bus_o", 32'(exc_bus_o), 32'(e.bus));
          check("hi_o", hi_o, e.hi);
          check("lo_o", lo_o, e.lo);
          check("whilo_o", 32'(whilo_o), 32'(e.whilo));
          check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
        end
        stall_cnt = 0;
      end
    end
  end

  // Bus responder: checks each request against the model, acks after its delay.
  initial begin : responder
    req_t cur;
    int   acc;
    logic [31:0] m;
    int   idx;
    acc = 0;
    cur.addr = '0; cur.we = 1'b0; cur.sel = '0; cur.wdata = '0; cur.delay = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst || !dmem_req) begin
        acc = 0;
        dmem_ack = 1'b0;
      end else begin
        if (acc == 0) begin
          check("req_expected", 32'(rq_q.size() > 0), 32'd1);
          if (rq_q.size() > 0) begin
            cur = rq_q.pop_front();
            check("dmem_addr", dmem_addr, cur.addr);
            check("dmem_we", 32'(dmem_we), 32'(cur.we));
            if (cur.we) begin
              check("dmem_sel", 32'(dmem_sel), 32'(cur.sel));
              check("dmem_wdata", dmem_wdata, cur.wdata);
            end
          end else begin
            cur.delay = 0;
          end
        end else begin
          check("dmem_addr_stable", dmem_addr, cur.addr);
        end
        idx = int'(dmem_addr[5:2]);
        if (acc == cur.delay) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            for (int i = 0; i < 4; i++)
              if (dmem_sel[i]) begin
                m = 32'hFF << (8 * i);
                bus_mem[idx] = (bus_mem[idx] & ~m) | (dmem_wdata & m);
              end
          end else begin
            dmem_rdata = bus_mem[idx];
          end
        end else begin
          dmem_ack = 1'b0;
          dmem_rdata = $urandom;
        end
        acc++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] w, a;
    req_t r;
    int   op;
    rst = 1'b0;
    llbit_clr_i = 1'b0;
    drive_random_side();
    mem_op_i = 4'd5; mem_addr_i = 32'h40; reg2_i = $urandom;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      ref_mem[i] = w;
      bus_mem[i] = w;
    end
    ref_mem[0] = 32'h12F4_5678;
    bus_mem[0] = 32'h12F4_5678;
    repeat (2) begin
      @(negedge clk);
      check("outputs_in_reset", 32'(any_out()), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    do_op(1, 32'h0000_1001, $urandom, 0, 1'b0);   // LB sign-extended, ack immediately
    do_op(7, 32'h0000_2002, 32'h0000_ABCD, 2, 1'b0); // SH, late ack
    do_op(2, 32'h0000_2003, 32'h0, 0, 1'b0);        // LBU read-back of SH lane
    do_op(5, 32'h0000_3001, 32'h0, 0, 1'b0);        // misaligned LW
    do_op(5, 32'h0000_3000, 32'h0, 4, 1'b0);        // no ack within TIMEOUT
    do_op(5, 32'h0000_3000, 32'h0, 3, 1'b0);        // ack on the TIMEOUT cycle
    do_op(8, 32'h0000_0024, 32'hCAFE_F00D, 1, 1'b0);
    do_op(3, 32'h0000_0026, 32'h0, 0, 1'b0);
    do_op(0, 32'h0, 32'h0, 0, 1'b0);
    do_op(13, 32'h0000_0001, 32'h0, 0, 1'b0);

    // Reset on the second ACCESS cycle abandons the access.
    drive_random_side();
    mem_op_i = 4'd5; mem_addr_i = 32'h0000_0040;
    r.addr = 32'h0000_0040; r.we = 1'b0; r.sel = 4'hF; r.wdata = 32'h0; r.delay = 10;
    rq_q.push_back(r);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs_zero", 32'(any_out()), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_still_zero", 32'(any_out()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_op(0, 32'h0, 32'h0, 0, 1'b0);
    do_op(5, 32'h0000_0040, 32'h0, 0, 1'b0);

`ifdef MEM_LSU_LLSC_EN
    do_op(9, 32'h0000_0010, 32'h0, 0, 1'b0);
    do_op(10, 32'h0000_0010, 32'h1234_5678, 1, 1'b0);
    do_op(9, 32'h0000_0014, 32'h0, 0, 1'b0);
    do_op(0, 32'h0, 32'h0, 0, 1'b1);
    do_op(10, 32'h0000_0014, 32'h8765_4321, 0, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 15);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(op, a, $urandom, $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
    end

    do_op(0, 32'h0, 32'h0, 0, 1'b0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("rq_drained", 32'(rq_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
